// File: rtl/bit_scan_encoder_if.sv
// Handshake bundle for bit_scan_encoder: vector input side and index output side.
interface bit_scan_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_last;

  // Environment side: offers vectors and consumes indices.
  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last
  );

  // Encoder side.
  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last
  );
endinterface

// File: rtl/bit_scan_encoder.sv
// bit_scan_encoder: captures a 32-bit mask and emits the index of each set bit,
// one per handshake. Default order is lowest bit first; define
// BITSCAN_MSB_FIRST_EN to emit the highest bit first instead.
// All outputs are registered; the selected index is re-encoded from the next
// value of pend so it always reflects the pend register without any path from
// the input-side handshake or out_ready.
module bit_scan_encoder (
  input  logic                 clk,
  input  logic                 rst,
  bit_scan_encoder_if.slave    bus,
  output logic                 busy
);

  localparam int unsigned VEC_W = 32;
  localparam int unsigned IDX_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state;
  logic [VEC_W-1:0]   pend;
  logic [VEC_W-1:0]   pend_clr;

  // Priority encode: lowest set bit, or highest when MSB-first is enabled.
  function automatic logic [IDX_W-1:0] pick(input logic [VEC_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
`ifdef BITSCAN_MSB_FIRST_EN
    for (int i = 0; i < VEC_W; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
`else
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
`endif
    return idx;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic single(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
  endfunction

  // Pending mask with the currently presented bit removed.
  always_comb begin
    pend_clr = pend & ~(VEC_W'(1) << bus.out_idx);
  end

  // Scan FSM with registered handshake, index and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pend          <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A zero vector is accepted and dropped without leaving IDLE.
          if (bus.in_valid && bus.in_ready && (bus.in_vec != '0)) begin
            state         <= SCAN;
            pend          <= bus.in_vec;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_idx   <= pick(bus.in_vec);
            bus.out_last  <= single(bus.in_vec);
            busy          <= 1'b1;
          end
        end
        SCAN: begin
          if (bus.out_ready) begin
            if (bus.out_last) begin
              state         <= IDLE;
              pend          <= '0;
              bus.in_ready  <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_idx   <= '0;
              bus.out_last  <= 1'b0;
              busy          <= 1'b0;
            end else begin
              pend          <= pend_clr;
              bus.out_idx   <= pick(pend_clr);
              bus.out_last  <= single(pend_clr);
            end
          end
        end
        default: begin
          state         <= IDLE;
          pend          <= '0;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.out_idx   <= '0;
          bus.out_last  <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Scoreboard bench for bit_scan_encoder: stimulus pushes expected {idx,last}
// pairs; a negedge monitor pops and compares on every output handshake.
module tb_bit_scan_encoder;

  logic clk;
  logic rst;
  logic busy;

  bit_scan_encoder_if intf ();

  bit_scan_encoder dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (intf.slave),
    .busy (busy)
  );

  typedef struct packed {
    logic [4:0] idx;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic last);
    exp_t e;
    e.idx  = 5'(idx);
    e.last = last;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every accepted output index against the scoreboard.
  always @(negedge clk) begin
    if (!rst && intf.out_valid && intf.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual_idx=%0d actual_last=%0b expected=none",
                 intf.out_idx, intf.out_last);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_idx", 32'(intf.out_idx), 32'(e.idx));
        check("out_last", 32'(intf.out_last), 32'(e.last));
      end
    end
  end

  // Offer a vector until accepted; returns at #1 after the accepting edge.
  task automatic send(input logic [31:0] vec);
    bit done;
    done = 1'b0;
    intf.in_vec   = vec;
    intf.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (intf.in_ready) begin
        step();
        done = 1'b1;
        break;
      end
      step();
    end
    intf.in_valid = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
    if (vec != 32'd0) begin
      check("first_valid_latency", 32'(intf.out_valid), 32'd1);
      check("busy_after_accept", 32'(busy), 32'd1);
    end else begin
      check("zero_in_ready", 32'(intf.in_ready), 32'd1);
      check("zero_no_valid", 32'(intf.out_valid), 32'd0);
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0 && intf.in_ready) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check("drain_in_budget", 32'(done), 32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    intf.in_valid  = 1'b0;
    intf.in_vec    = '0;
    intf.out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", 32'(intf.in_ready), 32'd1);
    check("rst_out_valid", 32'(intf.out_valid), 32'd0);
    check("rst_out_idx", 32'(intf.out_idx), 32'd0);
    check("rst_out_last", 32'(intf.out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // Sparse vector: three transfers on consecutive cycles.
    intf.out_ready = 1'b1;
`ifdef BITSCAN_MSB_FIRST_EN
    push(31, 1'b0); push(8, 1'b0); push(0, 1'b1);
`else
    push(0, 1'b0); push(8, 1'b0); push(31, 1'b1);
`endif
    send(32'h8000_0101);
    repeat (3) step();
    check("sparse_in_ready_after", 32'(intf.in_ready), 32'd1);
    check("sparse_valid_after", 32'(intf.out_valid), 32'd0);
    check("sparse_queue_empty", 32'(q.size()), 32'd0);

    // Full vector: 32 transfers at one per cycle.
    for (int i = 0; i < 32; i++) begin
`ifdef BITSCAN_MSB_FIRST_EN
      push(31 - i, i == 31);
`else
      push(i, i == 31);
`endif
    end
    send(32'hFFFF_FFFF);
    repeat (32) step();
    check("full_in_ready_after", 32'(intf.in_ready), 32'd1);
    check("full_busy_after", 32'(busy), 32'd0);
    check("full_queue_empty", 32'(q.size()), 32'd0);

    // Backpressure: out_ready pattern 0,0,1,0,1.
    intf.out_ready = 1'b0;
`ifdef BITSCAN_MSB_FIRST_EN
    push(2, 1'b0); push(1, 1'b1);
`else
    push(1, 1'b0); push(2, 1'b1);
`endif
    send(32'h0000_0006);
    begin
      logic rdy_pat [5];
      int   held    [5];
      rdy_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef BITSCAN_MSB_FIRST_EN
      held = '{2, 2, 2, 1, 1};
`else
      held = '{1, 1, 1, 2, 2};
`endif
      for (int i = 0; i < 5; i++) begin
        intf.out_ready = rdy_pat[i];
        check("bp_valid_held", 32'(intf.out_valid), 32'd1);
        check("bp_idx_held", 32'(intf.out_idx), 32'(held[i]));
        step();
      end
    end
    intf.out_ready = 1'b1;
    check("bp_in_ready_after", 32'(intf.in_ready), 32'd1);
    check("bp_queue_empty", 32'(q.size()), 32'd0);

    // Zero vector is swallowed.
    send(32'h0);
    step();
    check("zero_stays_idle_valid", 32'(intf.out_valid), 32'd0);
    check("zero_stays_idle_busy", 32'(busy), 32'd0);

    // Input offered while busy is ignored.
    intf.out_ready = 1'b0;
`ifdef BITSCAN_MSB_FIRST_EN
    push(1, 1'b0); push(0, 1'b1);
`else
    push(0, 1'b0); push(1, 1'b1);
`endif
    send(32'h0000_0003);
    intf.in_vec   = 32'h0000_00F0;
    intf.in_valid = 1'b1;
    step();
    intf.in_valid = 1'b0;
    check("busy_in_ready_low", 32'(intf.in_ready), 32'd0);
    intf.out_ready = 1'b1;
    wait_drain(20);
    repeat (3) step();
    check("busy_no_extra_valid", 32'(intf.out_valid), 32'd0);

    // Reset mid-scan drops remaining indices.
`ifdef BITSCAN_MSB_FIRST_EN
    push(7, 1'b0); push(6, 1'b0);
`else
    push(4, 1'b0); push(5, 1'b0);
`endif
    send(32'h0000_00F0);
    step();
    step();
    intf.out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 32'(intf.out_valid), 32'd0);
    check("midrst_in_ready", 32'(intf.in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_last", 32'(intf.out_last), 32'd0);
    check("midrst_out_idx", 32'(intf.out_idx), 32'd0);
    check("midrst_queue_empty", 32'(q.size()), 32'd0);
    q.delete();
    intf.out_ready = 1'b1;
    push(0, 1'b1);
    send(32'h0000_0001);
    wait_drain(20);

    repeat (3) step();
    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
